// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I definitions for the front-end pipeline.
// Contents: base opcode values, instruction-format encodings and the
// canonical NOP (addi x0,x0,0).
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/rv_decode.sv
// rv_decode: purely combinational RV32I field decoder.
// Ports:
//   instr_i            32-bit instruction word
//   opcode_o           instr[6:0]
//   rs1_o/rs2_o/rd_o   register fields, zero when the format does not use them
//   funct3_o/funct7_o  function fields, zero when not applicable
//   imm_o              sign-extended immediate (zero for R and illegal)
//   fmt_o              instruction format (fmt_e encoding)
//   rs1_en_o/rs2_en_o  register-read enables
//   rd_en_o            register-write enable (suppressed for rd = x0)
//   illegal_o          opcode not in the supported RV32I base set
module rv_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            rs1_en_o,
  output logic            rs2_en_o,
  output logic            rd_en_o,
  output logic            illegal_o
);

  fmt_e        fmt;
  logic [31:0] imm32;
  logic        writes_rd;

  always_comb begin
    fmt   = FMT_ILL;
    imm32 = '0;
    unique case (instr_i[6:0])
      OP_R: fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr_i[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_ILL;
        imm32 = '0;
      end
    endcase
  end

  // Formats that own rs1 (R/I/S/B) are exactly the ones that carry funct3.
  assign rs1_en_o  = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign rs2_en_o  = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  assign writes_rd = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
  // Writes to x0 are architecturally dropped, so never request them.
  assign rd_en_o   = writes_rd && (instr_i[11:7] != 5'd0);

  assign opcode_o  = instr_i[6:0];
  assign rs1_o     = rs1_en_o ? instr_i[19:15] : 5'd0;
  assign rs2_o     = rs2_en_o ? instr_i[24:20] : 5'd0;
  assign rd_o      = rd_en_o  ? instr_i[11:7]  : 5'd0;
  assign funct3_o  = rs1_en_o ? instr_i[14:12] : 3'd0;
  assign funct7_o  = (fmt == FMT_R) ? instr_i[31:25] : 7'd0;
  assign imm_o     = XLEN'($signed(imm32));
  assign fmt_o     = fmt;
  assign illegal_o = (fmt == FMT_ILL);

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: registered IF/ID boundary of the RV32I core.
// Buffers fetched {instr, pc} pairs in a DEPTH-entry FIFO behind a
// valid/ready handshake, supports a synchronous flush for redirects and
// decodes the head entry.
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   flush_i                drop all buffered entries on the next edge
//   in_valid/in_ready      fetch-side handshake; in_instr/in_pc payload
//   out_valid/out_ready    decode-side handshake on the head entry
//   out_instr/out_pc       head entry (NOP / 0 when empty)
//   opcode..illegal        decode of the head entry (decode of NOP when empty)
module if_id_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN  = 32,
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            rs1_en,
  output logic            rs2_en,
  output logic            rd_en,
  output logic            illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic            push, pop;
  logic            dec_illegal;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush_i) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage is never read while its slot is empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      instr_mem_q[wptr_q] <= in_instr;
      pc_mem_q[wptr_q]    <= in_pc;
    end
  end

  assign out_instr = out_valid ? instr_mem_q[rptr_q] : NOP;
  assign out_pc    = out_valid ? pc_mem_q[rptr_q]    : '0;

  rv_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (out_instr),
    .opcode_o  (opcode),
    .rs1_o     (rs1),
    .rs2_o     (rs2),
    .rd_o      (rd),
    .funct3_o  (funct3),
    .funct7_o  (funct7),
    .imm_o     (imm),
    .fmt_o     (fmt),
    .rs1_en_o  (rs1_en),
    .rs2_en_o  (rs2_en),
    .rd_en_o   (rd_en),
    .illegal_o (dec_illegal)
  );

  // An empty stage presents NOP, which must never be flagged.
  assign illegal = out_valid && dec_illegal;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_i;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            rs1_en, rs2_en, rd_en, illegal;

  if_id_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7),
    .imm(imm), .fmt(fmt), .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_en(rd_en),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef struct packed {
    logic        ov;
    logic        ir;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        e1;
    logic        e2;
    logic        ed;
    logic        ill;
  } obs_t;

  entry_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  // Reference: what the stage must show given how many entries it holds
  // and which one is oldest.
  function automatic obs_t model(input int sz, input entry_t e);
    obs_t        o;
    logic [31:0] w;
    int          f, sw;
    w  = (sz > 0) ? e.instr : 32'h0000_0013;
    sw = w;
    case (w[6:0])
      7'h33:               f = 0;
      7'h13, 7'h03, 7'h67: f = 1;
      7'h23:               f = 2;
      7'h63:               f = 3;
      7'h37, 7'h17:        f = 4;
      7'h6F:               f = 5;
      default:             f = 7;
    endcase
    o       = '0;
    o.ov    = (sz > 0);
    o.ir    = (sz < DEPTH);
    o.instr = w;
    o.pc    = (sz > 0) ? e.pc : 32'h0;
    o.opc   = w[6:0];
    case (f)
      1: o.imm = sw >>> 20;
      2: o.imm = ((sw >>> 25) * 32) + int'(w[11:7]);
      3: o.imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                 + int'(w[11:8]) * 2;
      4: o.imm = w & 32'hFFFF_F000;
      5: o.imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096
                 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      default: o.imm = 32'h0;
    endcase
    o.e1  = (f <= 3);
    o.e2  = (f == 0) || (f == 2) || (f == 3);
    o.ed  = ((f == 0) || (f == 1) || (f == 4) || (f == 5)) && (w[11:7] != 0);
    o.rs1 = o.e1 ? w[19:15] : 5'd0;
    o.rs2 = o.e2 ? w[24:20] : 5'd0;
    o.rd  = o.ed ? w[11:7]  : 5'd0;
    o.f3  = o.e1 ? w[14:12] : 3'd0;
    o.f7  = (f == 0) ? w[31:25] : 7'd0;
    o.fmt = 3'(f);
    o.ill = (sz > 0) && (f == 7);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {out_valid, in_ready, out_instr, out_pc, opcode, rs1, rs2, rd, funct3,
         funct7, imm, fmt, rs1_en, rs2_en, rd_en, illegal};
    return o;
  endfunction

  function automatic obs_t expected_now();
    entry_t hd;
    hd = '0;
    if (exp_q.size() > 0) hd = exp_q[0];
    return model(exp_q.size(), hd);
  endfunction

  task automatic chk(input string nm, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h expected=%h (ov/ir got %b%b exp %b%b, instr got %h exp %h, fmt got %0d exp %0d, imm got %h exp %h)",
               nm, $time, got, exp, got.ov, got.ir, exp.ov, exp.ir,
               got.instr, exp.instr, got.fmt, exp.fmt, got.imm, exp.imm);
    end
  endtask

  // Scoreboard update at each edge: flush wins, otherwise pop the head
  // and accept a new word only if the stage was not full before the edge.
  always @(posedge clk) begin
    int sz;
    if (rst_n) begin
      sz = exp_q.size();
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (out_ready && sz > 0) void'(exp_q.pop_front());
        if (in_valid && sz < DEPTH) exp_q.push_back({in_instr, in_pc});
      end
    end
  end

  // Monitor: compare every presented output against the scoreboard head.
  always @(negedge clk) begin
    chk("cycle", sample(), expected_now());
  end

  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush_i   = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    w = $urandom;
    if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 8)];
    return w;
  endfunction

  initial begin
    rst_n     = 1'b0;
    flush_i   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", sample(), model(0, '0));
    rst_n = 1'b1;

    // Directed decode of the named instructions.
    cyc(1, 32'h002081B3, 32'h100, 1, 0);
    cyc(1, 32'hFFF00293, 32'h104, 1, 0);
    cyc(1, 32'h123450B7, 32'h108, 1, 0);
    cyc(1, 32'h0020A423, 32'h10C, 1, 0);
    cyc(1, 32'hFE000EE3, 32'h110, 1, 0);
    cyc(1, 32'h00000000, 32'h114, 1, 0);
    cyc(1, 32'h0000006F, 32'h118, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);

    // Backpressure: A, B fill the stage, C stalls until space opens.
    cyc(1, 32'h00100093, 32'h200, 0, 0);
    cyc(1, 32'h00200113, 32'h204, 0, 0);
    cyc(1, 32'h00300193, 32'h208, 0, 0);
    cyc(1, 32'h00300193, 32'h208, 0, 0);
    cyc(1, 32'h00300193, 32'h208, 1, 0);
    cyc(1, 32'h00300193, 32'h208, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);

    // Flush with two buffered entries and a push attempt.
    cyc(1, 32'h00400213, 32'h300, 0, 0);
    cyc(1, 32'h00500293, 32'h304, 0, 0);
    cyc(1, 32'h00600313, 32'h308, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // Flush with one entry while push and pop are both offered.
    cyc(1, 32'h00700393, 32'h400, 0, 0);
    cyc(1, 32'h00800413, 32'h404, 1, 1);
    repeat (2) cyc(0, 0, 0, 1, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) != 0), rand_instr(), $urandom,
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
    end

    // Reset in the middle of a full stage.
    cyc(0, 0, 0, 0, 1);
    cyc(1, 32'h00900493, 32'h500, 0, 0);
    cyc(1, 32'h00A00513, 32'h504, 0, 0);
    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_reset", sample(), model(0, '0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 32'h00B00593, 32'h600, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Registered IF/ID pipeline stage for the RV32I core. Buffers fetched instructions with their PC in a DEPTH-entry FIFO behind a valid/ready handshake, supports flush for branch redirects, and fully decodes the head entry. Decoded outputs are register fields, format, register-use enables and a sign-extended immediate. It sits between the fetch unit and the register file/control unit and replaces the combinational field splitter. Non-applicable fields are driven to 0, never X.

Parameters:
XLEN, 32, datapath and PC width; the immediate is sign-extended to XLEN.
DEPTH, 2, FIFO entries (legal values 1..4); 2 gives full throughput under backpressure.
NOP, 32'h00000013, instruction presented on out_instr when the stage is empty (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush: discard all buffered entries
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept (count < DEPTH)
in_instr  in  32  fetched instruction
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts head
out_instr  out  32  head instruction (NOP when empty)
out_pc  out  XLEN  head PC (0 when empty)
opcode  out  7  head[6:0]
rs1  out  5  head[19:15] if rs1_en, else 0
rs2  out  5  head[24:20] if rs2_en, else 0
rd  out  5  head[11:7] if rd_en, else 0
funct3  out  3  head[14:12] for R/I/S/B, else 0
funct7  out  7  head[31:25] for R, else 0
imm  out  XLEN  sign-extended immediate per fmt; 0 for R or illegal
fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
rs1_en  out  1  rs1 read required (R, I, S, B)
rs2_en  out  1  rs2 read required (R, S, B)
rd_en  out  1  rd write (R, I, U, J) and rd != 0
illegal  out  1  out_valid and (head[1:0] != 2'b11 or unknown opcode)

Behaviour:
- Reset (async, rst_n=0): count=0, write/read pointers=0, out_valid=0, in_ready=1, out_instr=NOP, out_pc=0. Decode outputs reflect NOP: fmt=1, rs1_en=1, rd_en=0, imm=0, illegal=0.
- Push when in_valid & in_ready; pop when out_valid & out_ready. in_ready = (count != DEPTH) is combinational from registered count. No bypass path.
- Push-to-out_valid latency is 1 cycle. Simultaneous push and pop: count unchanged, pointers advance, FIFO order preserved. Pointers wrap modulo DEPTH.
- Full (count=DEPTH): in_ready=0, in_valid ignored. A pop in the same cycle does not allow a push in that cycle.
- Empty: out_valid=0. A pop attempt is a no-op.
- out_valid held with out_ready=0: every output is stable until the pop.
- flush_i=1: on the next edge count=0 and pointers=0. A concurrent push or pop in that cycle is discarded. flush_i has priority over the handshake, and in_ready is unaffected in the flush cycle.
- Opcode map:
  R = 0110011.
  I = 0010011, 0000011, 1100111.
  S = 0100011.
  B = 1100011.
  U = 0110111, 0010111.
  J = 1101111.
  Anything else gives fmt=7 with all enables 0 and imm=0.
- Immediate construction:
  I: {ins[31:20]}.
  S: {ins[31:25], ins[11:7]}.
  B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  U: {ins[31:12], 12'b0}.
  J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
  All are sign-extended from the top bit to XLEN.
- Decode is combinational from the registered head entry only, with no dependence on in_*.
- Reset asserted mid-stream: all entries lost immediately, outputs return to reset values asynchronously.

Decomposition:
- riscv_pkg holds: opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL), fmt encodings (FMT_R..FMT_J, FMT_ILL), and NOP_INSTR.
- One combinational sub-module, rv_decode: takes the 32-bit instruction and produces fields, fmt, enables, imm and illegal.
- if_id_stage holds the FIFO storage, pointers, count and flush logic, and instantiates rv_decode on the head entry.

Test Plan:
- Push 0x002081B3 (add x3,x1,x2), pc=0x100 -> next cycle: out_valid=1, fmt=0, rs1=1, rs2=2, rd=3, funct3=0, funct7=0, rd_en=1, imm=0, out_pc=0x100.
- Push 0xFFF00293 (addi x5,x0,-1) -> fmt=1, imm=0xFFFFFFFF, rd=5, rs2=0, rs2_en=0. Push 0x123450B7 (lui x1) -> fmt=4, imm=0x12345000, rs1_en=0.
- Push 0x0020A423 (sw x2,8(x1)) -> fmt=2, imm=8, rd=0, rd_en=0. Push 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC.
- DEPTH=2, out_ready=0, push A,B,C on consecutive cycles -> in_ready=0 after B, C stalled. Raise out_ready -> A, B, C delivered in order, one per cycle.
- Two entries buffered, assert flush_i with in_valid=1 -> next cycle out_valid=0, out_instr=NOP, count=0, and the pushed word is never delivered.
- Push 0x00000000 -> illegal=1, fmt=7, enables 0. Deassert rst_n mid-stream with 2 entries -> out_valid=0 immediately, in_ready=1.
